pl_wb_regfile: RTL and testbench
================================

Name: pl_wb_regfile

Overview:
- Write-back stage and general-purpose register file of the 5-stage pipeline. Sits at the far end of the MEM/WB pipeline register and consumes its outputs.
- Selects the write-back value (memory load data or ALU result) and writes it into a 32x32 register file.
- Serves the ID stage through two read ports with same-cycle write-through bypass.
- Counts retired register writes for debug.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- DW, 32, data width.
- CW, 32, width of the retired-write counter.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- wwreg  input  1  write enable from MEM/WB.
- wm2reg  input  1  write-back source select from MEM/WB: 1 = memory data, 0 = ALU result.
- wrno  input  DW  memory load data from MEM/WB.
- walu  input  DW  ALU result from MEM/WB.
- wrn  input  5  destination register number from MEM/WB.
- rna  input  5  read port A register number (ID stage).
- rnb  input  5  read port B register number (ID stage).
- qa  output  DW  read port A data.
- qb  output  DW  read port B data.
- wdi  output  DW  selected write-back value, exported to the forwarding muxes.
- wvalid  output  1  high when a real write is committing this cycle.
- dbg_rn  input  5  debug read register number.
- dbg_q  output  DW  debug read data; no bypass applied.
- wcount  output  CW  number of committed register writes since reset.

Behaviour:
- Reset is synchronous and active-high. When reset is high at a rising edge of clock:
  - all registers 1..31 are cleared to 0;
  - wcount is cleared to 0;
  - no write commits that cycle, even if wwreg = 1.
- While reset is high, all outputs evaluate combinationally as follows:
  - qa, qb and dbg_q read 0 once the registers are cleared;
  - wdi follows the mux;
  - wvalid = 0.
- Write-back mux (combinational): wdi = wm2reg ? wrno : walu.
- Write qualification (combinational): wvalid = wwreg & (wrn != 0) & ~reset.
- Write: at a rising edge of clock with wvalid = 1, reg[wrn] <= wdi. Write latency is 1 cycle into the storage.
- Register 0:
  - writes to it are discarded;
  - reads of it always return 0;
  - it is never bypassed.
- Read ports are combinational (zero latency):
  - qa = (rna == 0) ? 0 : (wvalid & (wrn == rna)) ? wdi : reg[rna].
  - qb is identical, using rnb.
- The bypass gives write-before-read semantics in the same cycle. ID therefore sees the value WB is committing, which removes the WB-to-ID hazard. Forwarding from EXE and MEM is outside this block.
- Both read ports may address the same register, including the write target. Both then return the bypassed value.
- dbg_q = reg[dbg_rn], or 0 when dbg_rn == 0. It shows storage only, with no bypass, so the value appears one cycle after the commit.
- wcount:
  - increments by 1 at every rising edge where wvalid = 1;
  - wraps modulo 2^CW without saturation;
  - does not count writes to register 0 or writes with wwreg = 0.
- X/undefined inputs: when wwreg = 0, the values of wrn, wrno, walu and wm2reg have no effect on state.
- No handshake or stall input: the pipeline bubble is encoded as wwreg = 0 from MEM/WB.

Test Plan:
- Reset clears state:
  - Preload reg5 = 0xDEADBEEF, then assert reset for 1 cycle while wwreg=1, wrn=5, walu=0x11.
  - Required after the edge: dbg_rn=5 gives dbg_q = 0; wcount = 0; wvalid was 0 during reset.
- ALU write and bypass:
  - wwreg=1, wm2reg=0, walu=0x00001234, wrn=7, rna=7.
  - Same cycle: qa = 0x00001234 and wdi = 0x00001234.
  - After the edge with wwreg=0: qa = 0x00001234 from storage, dbg_q(7) = 0x00001234, wcount = 1.
- Memory write select:
  - wwreg=1, wm2reg=1, wrno=0xCAFEF00D, walu=0x1, wrn=31.
  - Required after the edge: qb(rnb=31) = 0xCAFEF00D.
- Register 0 protection:
  - wwreg=1, wrn=0, walu=0xFFFFFFFF, rna=0, rnb=0.
  - Required: qa = qb = 0, wvalid = 0; dbg_q(0) = 0 after the edge; wcount unchanged.
- Disabled write ignored:
  - reg3 = 0xA5A5A5A5, then wwreg=0, wrn=3, walu=0x5A5A5A5A for 3 cycles.
  - Required: qa(rna=3) stays 0xA5A5A5A5 with no bypass; wcount unchanged.
- Back-to-back writes and dual-port read:
  - Consecutive cycles write reg2=0x10, reg2=0x20, reg9=0x30, with rna=2 and rnb=2 held.
  - Cycle 1: qa = qb = 0x10. Cycle 2: 0x20. Cycle 3: 0x20 from storage.
  - Final wcount = 3.
  - Set wcount to 2^CW-1 (force, or use CW=4 with 15 prior writes); one more write gives wcount = 0.

Source files
------------

// File: rtl/pl_wb_regfile.sv
// Write-back stage and 32x32 GPR file: selects the write-back value, commits it,
// serves two bypassed ID read ports plus an unbypassed debug port, counts commits.
module pl_wb_regfile #(
   parameter int NREG = 32,
   parameter int DW   = 32,
   parameter int CW   = 32
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          wwreg,
   input  logic          wm2reg,
   input  logic [DW-1:0] wrno,
   input  logic [DW-1:0] walu,
   input  logic [4:0]    wrn,
   input  logic [4:0]    rna,
   input  logic [4:0]    rnb,
   output logic [DW-1:0] qa,
   output logic [DW-1:0] qb,
   output logic [DW-1:0] wdi,
   output logic          wvalid,
   input  logic [4:0]    dbg_rn,
   output logic [DW-1:0] dbg_q,
   output logic [CW-1:0] wcount
);

   // Register 0 has no storage; reads of it are forced to zero below.
   logic [DW-1:0] rf [1:NREG-1];

   assign wdi    = wm2reg ? wrno : walu;
   assign wvalid = wwreg & (wrn != 5'd0) & ~reset;

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 1; i < NREG; i++) rf[i] <= '0;
         wcount <= '0;
      end else if (wvalid) begin
         rf[wrn] <= wdi;
         wcount  <= wcount + CW'(1);
      end
   end

   // Write-before-read bypass so ID sees the value WB commits this cycle.
   always_comb begin
      qa = '0;
      qb = '0;
      if (rna != 5'd0) qa = (wvalid && (wrn == rna)) ? wdi : rf[rna];
      if (rnb != 5'd0) qb = (wvalid && (wrn == rnb)) ? wdi : rf[rnb];
   end

   always_comb begin
      dbg_q = '0;
      if (dbg_rn != 5'd0) dbg_q = rf[dbg_rn];
   end

endmodule

// File: tb/tb_pl_wb_regfile.sv
// Directed bench for pl_wb_regfile: vector table plus reset and counter-wrap sequences.
module tb_pl_wb_regfile;

   localparam int DW = 32;
   localparam int CW = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          wwreg, wm2reg;
   logic [DW-1:0] wrno, walu;
   logic [4:0]    wrn, rna, rnb, dbg_rn;
   logic [DW-1:0] qa, qb, wdi, dbg_q;
   logic          wvalid;
   logic [CW-1:0] wcount;

   int errors = 0;
   int checks = 0;

   pl_wb_regfile #(.NREG(32), .DW(DW), .CW(CW)) dut (
      .clock(clock), .reset(reset), .wwreg(wwreg), .wm2reg(wm2reg),
      .wrno(wrno), .walu(walu), .wrn(wrn), .rna(rna), .rnb(rnb),
      .qa(qa), .qb(qb), .wdi(wdi), .wvalid(wvalid),
      .dbg_rn(dbg_rn), .dbg_q(dbg_q), .wcount(wcount)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        ww;
      logic        m2r;
      logic [31:0] rno;
      logic [31:0] alu;
      logic [4:0]  wn;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [4:0]  dn;
      logic [31:0] e_qa;
      logic [31:0] e_qb;
      logic [31:0] e_wdi;
      logic        e_wv;
      logic [31:0] e_dbg;
      logic [3:0]  e_cnt;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic ww, input logic m2r, input logic [31:0] rno,
                        input logic [31:0] alu, input logic [4:0] wn);
      wwreg = ww; wm2reg = m2r; wrno = rno; walu = alu; wrn = wn;
   endtask

   vec_t vt [14];

   initial begin
      reset = 1'b1;
      drive(1'b0, 1'b0, '0, '0, 5'd0);
      rna = 5'd5; rnb = 5'd5; dbg_rn = 5'd5;
      tick(); tick();
      chk("rst_wvalid", {31'd0, wvalid}, 32'd0);
      chk("rst_wcount", {28'd0, wcount}, 32'd0);
      chk("rst_qa", qa, 32'd0);
      chk("rst_dbg", dbg_q, 32'd0);

      // Preload reg5, then reset with a pending write that must not commit
      reset = 1'b0;
      drive(1'b1, 1'b0, '0, 32'hDEADBEEF, 5'd5);
      tick();
      drive(1'b0, 1'b0, '0, '0, 5'd0);
      #1;
      chk("preload_dbg", dbg_q, 32'hDEADBEEF);
      chk("preload_cnt", {28'd0, wcount}, 32'd1);
      reset = 1'b1;
      drive(1'b1, 1'b0, '0, 32'h11, 5'd5);
      #1;
      chk("rstw_wvalid", {31'd0, wvalid}, 32'd0);
      chk("rstw_wdi", wdi, 32'h11);
      tick();
      chk("rstw_qa", qa, 32'd0);
      reset = 1'b0;
      drive(1'b0, 1'b0, '0, '0, 5'd0);
      #1;
      chk("rstw_dbg", dbg_q, 32'd0);
      chk("rstw_cnt", {28'd0, wcount}, 32'd0);

      //          ww    m2r   wrno          walu          wn     ra     rb     dn     qa            qb            wdi           wv    dbg           cnt
      vt[0]  = '{1'b1, 1'b0, 32'h0BAD0BAD, 32'h00001234, 5'd7,  5'd7,  5'd0,  5'd7,  32'h00001234, 32'h0,        32'h00001234, 1'b1, 32'h0,        4'd0};
      vt[1]  = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd7,  5'd7,  5'd7,  5'd7,  32'h00001234, 32'h00001234, 32'h0,        1'b0, 32'h00001234, 4'd1};
      vt[2]  = '{1'b1, 1'b1, 32'hCAFEF00D, 32'h1,        5'd31, 5'd0,  5'd31, 5'd31, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 1'b1, 32'h0,        4'd1};
      vt[3]  = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd31, 5'd7,  5'd31, 5'd31, 32'h00001234, 32'hCAFEF00D, 32'h0,        1'b0, 32'hCAFEF00D, 4'd2};
      vt[4]  = '{1'b1, 1'b0, 32'h0,        32'hFFFFFFFF, 5'd0,  5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 32'h0,        4'd2};
      vt[5]  = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd0,  5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        1'b0, 32'h0,        4'd2};
      vt[6]  = '{1'b1, 1'b0, 32'h0,        32'hA5A5A5A5, 5'd3,  5'd3,  5'd0,  5'd3,  32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 1'b1, 32'h0,        4'd2};
      vt[7]  = '{1'b0, 1'b0, 32'h0,        32'h5A5A5A5A, 5'd3,  5'd3,  5'd3,  5'd3,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 32'hA5A5A5A5, 4'd3};
      vt[8]  = vt[7];
      vt[9]  = vt[7];
      vt[10] = '{1'b1, 1'b0, 32'h0,        32'h10,       5'd2,  5'd2,  5'd2,  5'd2,  32'h10,       32'h10,       32'h10,       1'b1, 32'h0,        4'd3};
      vt[11] = '{1'b1, 1'b0, 32'h0,        32'h20,       5'd2,  5'd2,  5'd2,  5'd2,  32'h20,       32'h20,       32'h20,       1'b1, 32'h10,       4'd4};
      vt[12] = '{1'b1, 1'b0, 32'h0,        32'h30,       5'd9,  5'd2,  5'd2,  5'd9,  32'h20,       32'h20,       32'h30,       1'b1, 32'h0,        4'd5};
      vt[13] = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd0,  5'd2,  5'd9,  5'd2,  32'h20,       32'h30,       32'h0,        1'b0, 32'h20,       4'd6};

      for (int i = 0; i < 14; i++) begin
         drive(vt[i].ww, vt[i].m2r, vt[i].rno, vt[i].alu, vt[i].wn);
         rna = vt[i].ra; rnb = vt[i].rb; dbg_rn = vt[i].dn;
         #1;
         chk($sformatf("v%0d_qa", i), qa, vt[i].e_qa);
         chk($sformatf("v%0d_qb", i), qb, vt[i].e_qb);
         chk($sformatf("v%0d_wdi", i), wdi, vt[i].e_wdi);
         chk($sformatf("v%0d_wvalid", i), {31'd0, wvalid}, {31'd0, vt[i].e_wv});
         chk($sformatf("v%0d_dbg", i), dbg_q, vt[i].e_dbg);
         chk($sformatf("v%0d_cnt", i), {28'd0, wcount}, {28'd0, vt[i].e_cnt});
         tick();
      end

      // Counter sits at 6; nine more commits reach 15, the next wraps to 0
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, 1'b0, '0, 32'(i + 100), 5'd4);
         tick();
      end
      drive(1'b0, 1'b0, '0, '0, 5'd0);
      dbg_rn = 5'd4;
      #1;
      chk("wrap_pre", {28'd0, wcount}, 32'd15);
      chk("wrap_dbg", dbg_q, 32'd108);
      drive(1'b1, 1'b0, '0, 32'h77, 5'd4);
      tick();
      drive(1'b0, 1'b0, '0, '0, 5'd0);
      #1;
      chk("wrap_post", {28'd0, wcount}, 32'd0);
      chk("wrap_dbg2", dbg_q, 32'h77);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
